// File: rtl/rotr_pipe_if.sv
// Operand/result handshake bundle for the pipelined rotate-right unit.
// master drives operands and consumes results; slave is the rotate unit.
interface rotr_pipe_if #(
    parameter int DATA_WIDTH = 256
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] a_in;
    logic [DATA_WIDTH-1:0] shift_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] a_out;

    modport master (
        output in_valid, a_in, shift_in, out_ready,
        input  in_ready, out_valid, a_out
    );

    modport slave (
        input  in_valid, a_in, shift_in, out_ready,
        output in_ready, out_valid, a_out
    );
endinterface

// File: rtl/rotr_pipe.sv
// Three-stage rotate-right unit: stage 1 rotates by s[2:0], stage 2 by 8*s[5:3],
// stage 3 by 64*s[SHIFT_WIDTH-1:6]. Any stall freezes every stage in place.
module rotr_pipe #(
    parameter int DATA_WIDTH  = 256,
    parameter int SHIFT_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic       busy,
    rotr_pipe_if.slave bus
);

    function automatic logic [DATA_WIDTH-1:0] rotr(input logic [DATA_WIDTH-1:0] x,
                                                   input int unsigned           amt);
        return DATA_WIDTH'({x, x} >> amt);
    endfunction

    logic                    advance;
    logic                    v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [DATA_WIDTH-1:0]   s1_data_q, s1_data_d;
    logic [SHIFT_WIDTH-1:3]  s1_amt_q, s1_amt_d;
    logic [DATA_WIDTH-1:0]   s2_data_q, s2_data_d;
    logic [SHIFT_WIDTH-1:6]  s2_amt_q, s2_amt_d;
    logic [DATA_WIDTH-1:0]   a_out_q, a_out_d;

    // Amount bits above SHIFT_WIDTH carry no meaning for a power-of-two width.
    logic unused_shift_hi;
    assign unused_shift_hi = ^bus.shift_in[DATA_WIDTH-1:SHIFT_WIDTH];

    assign advance       = enable && (!v3_q || bus.out_ready);
    assign bus.in_ready  = advance;
    assign bus.out_valid = v3_q;
    assign bus.a_out     = a_out_q;
    assign busy          = v1_q | v2_q | v3_q;

    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block leaves a
        // signal unassigned; that is what keeps it from inferring latches.
        v1_d      = v1_q;
        v2_d      = v2_q;
        v3_d      = v3_q;
        s1_data_d = s1_data_q;
        s1_amt_d  = s1_amt_q;
        s2_data_d = s2_data_q;
        s2_amt_d  = s2_amt_q;
        a_out_d   = a_out_q;
        if (advance) begin
            v1_d = bus.in_valid;
            v2_d = v1_q;
            v3_d = v2_q;
            // Data only moves with a valid token, so bubbles cost no toggling.
            if (bus.in_valid) begin
                s1_data_d = rotr(bus.a_in, 32'(bus.shift_in[2:0]));
                s1_amt_d  = bus.shift_in[SHIFT_WIDTH-1:3];
            end
            if (v1_q) begin
                s2_data_d = rotr(s1_data_q, 32'({s1_amt_q[5:3], 3'd0}));
                s2_amt_d  = s1_amt_q[SHIFT_WIDTH-1:6];
            end
            if (v2_q) begin
                a_out_d = rotr(s2_data_q, 32'({s2_amt_q, 6'd0}));
            end
        end
    end

    // NOTE: the data and amount registers are reset too, so a_out reads 0 after
    // reset rather than whatever was left in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            s1_data_q <= '0;
            s1_amt_q  <= '0;
            s2_data_q <= '0;
            s2_amt_q  <= '0;
            a_out_q   <= '0;
        end else begin
            // NOTE: non-blocking updates let each stage read the previous
            // stage's old value, which is what makes this a pipeline.
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            v3_q      <= v3_d;
            s1_data_q <= s1_data_d;
            s1_amt_q  <= s1_amt_d;
            s2_data_q <= s2_data_d;
            s2_amt_q  <= s2_amt_d;
            a_out_q   <= a_out_d;
        end
    end

endmodule

// File: tb/tb_rotr_pipe.sv
// Randomised bench for rotr_pipe: every result is checked against a bit-level
// rotate model fed from a queue of accepted operations.
module tb_rotr_pipe;

    localparam int DW = 256;

    logic clk;
    logic rst_n;
    logic enable;
    logic busy;

    rotr_pipe_if #(.DATA_WIDTH(DW)) bus ();

    rotr_pipe #(.DATA_WIDTH(DW), .SHIFT_WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .busy   (busy),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic          s_ready, s_valid, s_busy;
    logic [DW-1:0] s_aout;
    logic [DW-1:0] exp_q[$];

    // a_out[j] = a[(j + s) mod 256], s = low 8 bits of the amount.
    function automatic logic [DW-1:0] ref_rotr(input logic [DW-1:0] a, input logic [DW-1:0] sh);
        logic [DW-1:0] r;
        int unsigned   s;
        s = {24'd0, sh[7:0]};
        for (int j = 0; j < DW; j++) r[j] = a[(j + s) % DW];
        return r;
    endfunction

    function automatic logic [DW-1:0] rand256();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Drive one cycle's inputs mid-cycle, sample outputs before the next rising edge.
    task automatic step(input logic en, input logic iv, input logic [DW-1:0] a,
                        input logic [DW-1:0] sh, input logic ordy);
        @(negedge clk);
        enable        = en;
        bus.in_valid  = iv;
        bus.a_in      = a;
        bus.shift_in  = sh;
        bus.out_ready = ordy;
        #1;
        s_ready = bus.in_ready;
        s_valid = bus.out_valid;
        s_busy  = busy;
        s_aout  = bus.a_out;
        @(posedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        enable        = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a_in      = '0;
        bus.shift_in  = '0;
        bus.out_ready = 1'b0;
        #12;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (bus.a_out !== '0) begin bad++; $display("FAIL reset_a_out: got %h want 0", bus.a_out); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One operation into an idle pipe; result must appear exactly 3 cycles after accept.
    task automatic test_single(input string name, input logic [DW-1:0] a,
                               input logic [DW-1:0] sh, input logic [DW-1:0] want);
        int   lat;
        logic found;
        lat   = 0;
        found = 1'b0;
        step(1'b1, 1'b1, a, sh, 1'b1);
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL %s_accept: in_ready=%b want 1", name, s_ready); end
        for (int k = 0; k < 10 && !found; k++) begin
            step(1'b1, 1'b0, '0, '0, 1'b1);
            lat++;
            if (s_valid === 1'b1) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("FAIL %s_timeout: no out_valid within 10 cycles", name); end
        total++; if (lat != 3) begin bad++; $display("FAIL %s_latency: got %0d want 3", name, lat); end
        total++; if (s_aout !== want) begin bad++; $display("FAIL %s_value: got %h want %h", name, s_aout, want); end
    endtask

    task automatic test_stages();
        int            amts[6] = '{7, 8, 63, 64, 200, 255};
        logic [DW-1:0] one, sh, want;
        one = '0;
        one[0] = 1'b1;
        test_single("identity", one, '0, one);
        want = '0;
        want[DW-1] = 1'b1;
        test_single("rot1", one, {{(DW-1){1'b0}}, 1'b1}, want);
        foreach (amts[i]) begin
            sh = '1;
            sh[7:0] = amts[i][7:0];
            want = one << ((DW - amts[i]) % DW);
            test_single($sformatf("stage_s%0d", amts[i]), one, sh, want);
        end
    endtask

    task automatic test_back_to_back();
        int            first, last, n, drops;
        logic [DW-1:0] a, sh, want;
        logic          iv;
        first = -1; last = -1; n = 0; drops = 0;
        for (int i = 0; i < 64 + 12; i++) begin
            iv = (i < 64);
            a  = rand256();
            sh = rand256();
            step(1'b1, iv, a, sh, 1'b1);
            if (s_ready !== 1'b1) drops++;
            if (s_valid === 1'b1) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                total++; if (s_aout !== want) begin bad++; $display("FAIL b2b_result%0d: got %h want %h", n, s_aout, want); end
                if (first < 0) first = cyc;
                last = cyc;
                n++;
            end
            if (iv && s_ready) exp_q.push_back(ref_rotr(a, sh));
        end
        total++; if (n != 64) begin bad++; $display("FAIL b2b_count: got %0d want 64", n); end
        total++; if (last - first != 63) begin bad++; $display("FAIL b2b_consecutive: span %0d want 63", last - first); end
        total++; if (drops != 0) begin bad++; $display("FAIL b2b_in_ready: dropped %0d cycles want 0", drops); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_leftover: %0d want 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] pa, psh, prev_aout, want;
        logic          iv, ordy, prev_stall, exp_ready;
        int            sent;
        pa = rand256(); psh = rand256();
        prev_stall = 1'b0; prev_aout = '0; sent = 0;
        for (int i = 0; i < 600 && (sent < 60 || exp_q.size() > 0); i++) begin
            iv   = (sent < 60) && ($urandom_range(3) != 0);
            ordy = (i >= 20 && i < 25) ? 1'b0 : 1'($urandom_range(1));
            step(1'b1, iv, pa, psh, ordy);
            exp_ready = !(s_valid && !ordy);
            total++; if (s_ready !== exp_ready) begin bad++; $display("FAIL bp_in_ready@%0d: got %b want %b", i, s_ready, exp_ready); end
            if (prev_stall && s_valid) begin
                total++; if (s_aout !== prev_aout) begin bad++; $display("FAIL bp_stable@%0d: got %h want %h", i, s_aout, prev_aout); end
            end
            prev_stall = s_valid && !ordy;
            prev_aout  = s_aout;
            if (s_valid && ordy) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                total++; if (s_aout !== want) begin bad++; $display("FAIL bp_result@%0d: got %h want %h", i, s_aout, want); end
            end
            if (iv && s_ready) begin
                exp_q.push_back(ref_rotr(pa, psh));
                sent++;
                pa = rand256(); psh = rand256();
            end
        end
        total++; if (sent != 60 || exp_q.size() != 0) begin bad++; $display("FAIL bp_drain: sent %0d pending %0d want 60/0", sent, exp_q.size()); end
    endtask

    task automatic test_enable_freeze();
        logic [DW-1:0] a1, s1, a2, s2, snap_a;
        logic          snap_v, found;
        int            lat;
        a1 = rand256(); s1 = rand256(); a2 = rand256(); s2 = rand256();
        step(1'b1, 1'b1, a1, s1, 1'b1);
        step(1'b1, 1'b1, a2, s2, 1'b1);
        lat = 1;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, rand256(), rand256(), 1'b1);
            lat++;
            if (k == 0) begin snap_v = s_valid; snap_a = s_aout; end
            total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL freeze_in_ready%0d: got %b want 0", k, s_ready); end
            total++; if (s_busy !== 1'b1) begin bad++; $display("FAIL freeze_busy%0d: got %b want 1", k, s_busy); end
            total++; if (s_valid !== snap_v || s_aout !== snap_a) begin bad++; $display("FAIL freeze_hold%0d: got %b/%h want %b/%h", k, s_valid, s_aout, snap_v, snap_a); end
        end
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            step(1'b1, 1'b0, '0, '0, 1'b1);
            lat++;
            if (s_valid === 1'b1) found = 1'b1;
        end
        total++; if (lat != 7) begin bad++; $display("FAIL freeze_latency: got %0d want 7", lat); end
        total++; if (s_aout !== ref_rotr(a1, s1)) begin bad++; $display("FAIL freeze_op1: got %h want %h", s_aout, ref_rotr(a1, s1)); end
        step(1'b1, 1'b0, '0, '0, 1'b1);
        total++; if (s_valid !== 1'b1 || s_aout !== ref_rotr(a2, s2)) begin bad++; $display("FAIL freeze_op2: got %b/%h want 1/%h", s_valid, s_aout, ref_rotr(a2, s2)); end
        step(1'b1, 1'b0, '0, '0, 1'b1);
    endtask

    task automatic test_reset_midflight();
        logic [DW-1:0] want;
        int            stale;
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, rand256() | 256'd1, 256'd0, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre_valid: got %b want 1", bus.out_valid); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        total++; if (bus.a_out !== '0) begin bad++; $display("FAIL midrst_a_out: got %h want 0", bus.a_out); end
        #1 rst_n = 1'b1;
        exp_q.delete();
        stale = 0;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b0, '0, '0, 1'b1);
            if (s_valid !== 1'b0) stale++;
        end
        total++; if (stale != 0) begin bad++; $display("FAIL midrst_stale: got %0d valid cycles want 0", stale); end
        want = '0;
        want[251] = 1'b1;
        test_single("post_reset", 256'd1, 256'd5, want);
    endtask

    initial begin
        test_reset();
        test_stages();
        test_back_to_back();
        test_backpressure();
        test_enable_freeze();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
